// File: rtl/lcm_unit.sv
// lcm_unit: computes lcm = (a*b)/g with a shift-add multiplier followed by a restoring divider
// Ports:
//   clk    - system clock, all state updates on posedge
//   reset  - asynchronous active-high reset, discards any in-flight computation
//   start  - request, sampled only while idle
//   a, b   - operands (W bits), g - gcd of a and b from the gcd block (W bits)
//   busy   - high from the cycle after start is accepted until done
//   done   - one-cycle pulse marking lcm valid
//   lcm    - 2W-bit result, held until the next completed operation
//   err    - only with LCM_ERR_EN: g was 0 or a*b is not divisible by g
// Optional feature macro: LCM_ERR_EN
module lcm_unit #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   g,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] lcm
`ifdef LCM_ERR_EN
  ,
  output logic           err
`endif
);
  localparam int CW = $clog2(2 * W);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t         r_state, w_next;
  logic [2*W-1:0] r_mcand, r_acc, r_lcm;
  logic [W-1:0]   r_mplier, r_g, r_rem;
  logic [CW-1:0]  r_cnt;
  logic           r_zero, r_done;
  logic           w_zero_in, w_ge;
  logic [W:0]     w_shift;
`ifdef LCM_ERR_EN
  logic           r_err;
`endif
  assign w_zero_in = a == '0 || b == '0 || g == '0;
  // r_acc holds the product after MUL and is reused as the quotient shift register in DIV
  assign w_shift = {r_rem, r_acc[2*W-1]};
  assign w_ge = w_shift >= {1'b0, r_g};
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (start ? (w_zero_in ? FIN : MUL) : IDLE)
           : r_state == MUL  ? (r_cnt == '0 ? DIV : MUL)
           : r_state == DIV  ? (r_cnt == '0 ? FIN : DIV)
           : IDLE;
  always_comb begin
    busy = r_state != IDLE;
    done = r_done;
    lcm  = r_lcm;
`ifdef LCM_ERR_EN
    err  = r_err;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_g      <= '0;
      r_cnt    <= '0;
      r_zero   <= 1'b0;
      r_lcm    <= '0;
      r_done   <= 1'b0;
`ifdef LCM_ERR_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= r_state == FIN;
      if (r_state == IDLE && start) begin
        r_mcand  <= {{W{1'b0}}, a};
        r_mplier <= b;
        r_g      <= g;
        r_acc    <= '0;
        r_rem    <= '0;
        r_zero   <= w_zero_in;
        r_cnt    <= CW'(W - 1);
      end else if (r_state == MUL) begin
        r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt == '0 ? CW'(2 * W - 1) : r_cnt - CW'(1);
      end else if (r_state == DIV) begin
        r_acc <= {r_acc[2*W-2:0], w_ge};
        // partial remainder stays below g, so after a successful subtract the top bit is always 0
        r_rem <= w_ge ? W'(w_shift - {1'b0, r_g}) : w_shift[W-1:0];
        r_cnt <= r_cnt - CW'(1);
      end else if (r_state == FIN) begin
        r_lcm <= r_zero ? '0 : r_acc;
`ifdef LCM_ERR_EN
        r_err <= r_g == '0 || r_rem != '0;
`endif
      end
    end
endmodule

// File: tb/tb_lcm_unit.sv
// tb_lcm_unit: scoreboard bench for lcm_unit
module tb_lcm_unit;
  localparam int W = 8;
  typedef struct {
    logic [2*W-1:0] l;
    logic           e;
  } exp_t;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0, g = '0;
  logic           busy, done;
  logic [2*W-1:0] lcm;
`ifdef LCM_ERR_EN
  logic           err;
`endif
  int   total = 0, bad = 0;
  exp_t sb[$];
  exp_t m_e;
  logic prev_done = 1'b0;
  always #5 clk = ~clk;
  lcm_unit #(.W(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
    .g(g),
    .busy(busy),
    .done(done),
    .lcm(lcm)
`ifdef LCM_ERR_EN
    ,
    .err(err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int gcd_f(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse", 32'(prev_done), 0);
      chk("done_busy", 32'(busy), 0);
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        m_e = sb.pop_front();
        chk("lcm", 32'(lcm), 32'(m_e.l));
`ifdef LCM_ERR_EN
        chk("err", 32'(err), 32'(m_e.e));
`endif
      end
    end
    prev_done = done;
  end
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ig, input bit poke);
    int   n, p, lat;
    exp_t e;
    p = int'(ia) * int'(ib);
    e.l = (ia == 0 || ib == 0 || ig == 0) ? '0 : (2*W)'(p / int'(ig));
    e.e = (ig == 0) ? 1'b1 : (p % int'(ig) != 0);
    lat = (ia == 0 || ib == 0 || ig == 0) ? 1 : 3 * W + 1;
    sb.push_back(e);
    a = ia;
    b = ib;
    g = ig;
    start = 1'b1;
    @(negedge clk);
    n = 0;
    chk("busy_on", 32'(busy), 1);
    while (!done && n < 100) begin
      start = poke && (n == 3 || n == 10 || n == 24);
      if (poke) begin
        a = W'($urandom);
        b = W'($urandom);
        g = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(lat));
  endtask
  initial begin
    int x, y;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lcm", 32'(lcm), 0);
    reset = 1'b0;
    @(negedge clk);
    run_op(8'd200, 8'd68, 8'd4, 1'b0);
    run_op(8'd120, 8'd40, 8'd40, 1'b0);
    run_op(8'd255, 8'd2, 8'd1, 1'b0);
    run_op(8'd78, 8'd169, 8'd13, 1'b0);
    run_op(8'd225, 8'd20, 8'd5, 1'b0);
    run_op(8'd2, 8'd2, 8'd2, 1'b0);
    run_op(8'd0, 8'd5, 8'd5, 1'b0);
    run_op(8'd5, 8'd4, 8'd0, 1'b0);
    run_op(8'd255, 8'd255, 8'd255, 1'b0);
    run_op(8'd10, 8'd15, 8'd4, 1'b0);
    run_op(8'd100, 8'd72, 8'd4, 1'b1);
    @(negedge clk);
    chk("lcm_hold", 32'(lcm), 1800);
    chk("done_low", 32'(done), 0);
    a = 8'd153;
    b = 8'd18;
    g = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_lcm", 32'(lcm), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_lcm_stays", 32'(lcm), 0);
    run_op(8'd153, 8'd18, 8'd9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(1, 255);
      y = $urandom_range(1, 255);
      run_op(W'(x), W'(y), W'(gcd_f(x, y)), 1'b0);
    end
    for (int i = 0; i < 3; i++)
      run_op(W'($urandom_range(0, 255)), W'($urandom_range(1, 255)), W'($urandom_range(1, 255)), 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
